// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the packed convolution core and its
// downstream result serializer.
package conv_pkg;

  localparam int CONV_N    = 16;
  localparam int CONV_LEN1 = 3;
  localparam int CONV_LEN2 = 50;

  // Samples in one full linear-convolution result frame.
  function automatic int conv_num(input int len1, input int len2);
    return len1 + len2 - 1;
  endfunction

  // Index width able to address every sample of a frame (at least 1 bit).
  function automatic int conv_iw(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } conv_state_e;

endpackage

// File: rtl/conv_result_serializer_if.sv
// Frame-in / sample-out handshake bundle of the convolution result serializer.
interface conv_result_serializer_if
  import conv_pkg::*;
#(
  parameter int N   = CONV_N,
  parameter int NUM = conv_num(CONV_LEN1, CONV_LEN2)
);
  localparam int IW = conv_iw(NUM);

  logic                   in_valid;
  logic                   in_ready;
  logic [NUM*2*N-1:0]     conv_result;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [N-1:0]    out_data;
  logic [IW-1:0]          out_index;
  logic                   out_last;
  logic                   sat_flag;

  // Serializer side.
  modport slave (
    input  in_valid, conv_result, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, sat_flag
  );

  // Environment side: frame producer plus sample consumer.
  modport master (
    output in_valid, conv_result, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, sat_flag
  );

endinterface

// File: rtl/q_round_sat.sv
// Rescales one full-precision signed sample to a narrower Q format:
// arithmetic shift right with round-half-up, then saturation.
module q_round_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  // One guard bit keeps the rounding add from overflowing at the top of range.
  localparam int EW  = IN_W + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EW-1:0] RND =
    (SHIFT > 0) ? ({{(EW-1){1'b0}}, 1'b1} << RSH) : {EW{1'b0}};
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0] shifted;

  function automatic logic signed [EW-1:0] round_shift(input logic signed [IN_W-1:0] v);
    logic signed [EW-1:0] ext;
    ext = {v[IN_W-1], v};
    ext = ext + RND;
    return ext >>> SHIFT;
  endfunction

  function automatic logic is_sat(input logic signed [EW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [EW-1:0] v);
    if (v > MAXV) return MAXV[OUT_W-1:0];
    if (v < MINV) return MINV[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  // Round, shift and clamp the sample; flag when clamping was needed.
  always_comb begin
    shifted = round_shift(x);
    y       = clamp(shifted);
    sat     = is_sat(shifted);
  end

endmodule

// File: rtl/conv_result_serializer.sv
// Captures one packed convolution result frame and streams it out one
// rescaled sample per valid/ready beat, with a sticky saturation flag.
module conv_result_serializer
  import conv_pkg::*;
#(
  parameter int N     = CONV_N,
  parameter int LEN1  = CONV_LEN1,
  parameter int LEN2  = CONV_LEN2,
  parameter int SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_result_serializer_if.slave bus
);

  localparam int NUM = conv_num(LEN1, LEN2);
  localparam int IW  = conv_iw(NUM);
  localparam int W   = 2 * N;

  conv_state_e         state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                sat_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic                last_d;
  logic signed [W-1:0] frame_q [NUM];

  logic                accept;
  logic                beat;
  logic signed [W-1:0] sample;
  logic signed [N-1:0] scaled;
  logic                scaled_sat;

  // in_ready_q is high exactly in IDLE, out_valid_q exactly in STREAM.
  assign accept = in_ready_q & bus.in_valid;
  assign beat   = out_valid_q & bus.out_ready;

  assign idx_d  = idx_q + IW'(1);
  assign last_d = (idx_d == IW'(NUM - 1));

  // Frame storage is datapath only; it is qualified by the FSM, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM; i++) begin
        frame_q[i] <= bus.conv_result[i*W +: W];
      end
    end
  end

  assign sample = frame_q[idx_q];

  q_round_sat #(
    .IN_W  (W),
    .OUT_W (N),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .x   (sample),
    .y   (scaled),
    .sat (scaled_sat)
  );

  // Capture/stream control with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= STREAM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= (NUM == 1);
            sat_q       <= 1'b0;
            idx_q       <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            sat_q <= sat_q | scaled_sat;
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              idx_q       <= '0;
            end else begin
              idx_q      <= idx_d;
              out_last_q <= last_d;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          idx_q       <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.sat_flag  = sat_q;
  // Frame register is unreset, so the sample is forced to zero outside STREAM.
  assign bus.out_data  = out_valid_q ? scaled : '0;

endmodule
